// File: rtl/param_sp_ram.sv
// Parametrised single-port RAM: registered read with valid strobe, per-lane write
// enables, out-of-range detection and a sweep that fills every word with CLR_VAL.
module param_sp_ram #(
  parameter int                 DATA_W  = 8,
  parameter int                 LANE_W  = 8,
  parameter int                 ADDR_W  = 6,
  parameter int                 DEPTH   = 64,
  parameter logic [DATA_W-1:0]  CLR_VAL = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        mode,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [DATA_W-1:0]           data_in,
  input  logic [DATA_W/LANE_W-1:0]    be,
  input  logic                        clr,
  output logic [DATA_W-1:0]           data_out,
  output logic                        rd_valid,
  output logic                        busy,
  output logic                        addr_err
);

  localparam int                LANES    = DATA_W / LANE_W;
  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_out_q;
  logic                rd_valid_q;
  logic                addr_err_q;

  logic                accept;
  logic                in_range;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [LANES-1:0]    wr_be;
  logic [DATA_W-1:0]   rd_word;

  // A clr request in IDLE wins over any access presented on the same edge.
  assign accept   = (state_q == IDLE) && !clr && en;
  assign in_range = {1'b0, addr} < DEPTH_W;

  // The sweep and normal writes share one write path; rst blocks both.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = addr;
    wr_data = data_in;
    wr_be   = be;
    if (!rst) begin
      if (state_q == CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = cnt_q;
        wr_data = CLR_VAL;
        wr_be   = '1;
      end else begin
        wr_en = accept && mode && in_range;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [LANE_W-1:0] mem [DEPTH];

      always_ff @(posedge clk) begin
        if (wr_en && wr_be[gi]) begin
          mem[wr_addr] <= wr_data[gi*LANE_W +: LANE_W];
        end
      end

      assign rd_word[gi*LANE_W +: LANE_W] = mem[addr];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= accept && !mode;
      addr_err_q <= accept && !in_range;
      // Out-of-range reads still complete, returning zero.
      if (accept && !mode) begin
        data_out_q <= in_range ? rd_word : '0;
      end
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign addr_err = addr_err_q;
  assign busy     = (state_q == CLEAR);

endmodule

// File: doc/param_sp_ram.md
# param_sp_ram

Parametrised single-port RAM with a registered read port, per-lane write enables, out-of-range address detection and a hardware clear sequencer. The clear sequencer fills every location with a fixed value after reset or on request. It generalises the team's fixed 64x8 single-port RAM in width and depth, and replaces its asynchronous read with a one-cycle registered read plus a valid strobe. It is the standard scratch/buffer memory for datapath blocks that need known contents after reset.

## Interface
- DATA_W, 8: word width; must be a multiple of LANE_W.
- LANE_W, 8: write-enable granularity; LANES = DATA_W/LANE_W.
- ADDR_W, 6: address width.
- DEPTH, 64: number of words; 1 ≤ DEPTH ≤ 2^ADDR_W.
- CLR_VAL, 0: DATA_W-bit value written to every word by a clear sweep.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  access request.
- mode  in  1  1 = write, 0 = read (sampled with en).
- addr  in  ADDR_W  word address.
- data_in  in  DATA_W  write data.
- be  in  LANES  per-lane write enable; lane i is bits [i*LANE_W +: LANE_W].
- clr  in  1  request a clear sweep.
- data_out  out  DATA_W  registered read data.
- rd_valid  out  1  one-cycle strobe: data_out updated by the access one edge earlier.
- busy  out  1  clear sweep in progress; accesses are ignored.
- addr_err  out  1  one-cycle strobe: the accepted access had addr ≥ DEPTH.

## Operation
- FSM states: CLEAR, IDLE. Sweep counter cnt spans 0..DEPTH-1.
- rst high at an edge: state ← CLEAR, cnt ← 0, data_out ← 0, rd_valid ← 0, addr_err ← 0. busy = 1 (busy is 1 exactly when state == CLEAR). Memory contents are not touched while rst is high.
- CLEAR, rst low, each edge: mem[cnt] ← CLR_VAL.
  - If cnt == DEPTH-1: state ← IDLE. Otherwise cnt ← cnt+1.
  - en and clr are ignored. data_out holds its value. rd_valid and addr_err stay 0.
- IDLE, clr high at an edge: state ← CLEAR, cnt ← 0. Any simultaneous en access is dropped: no write, no rd_valid.
- IDLE, clr low, en high = accepted access.
  - Write (mode=1), addr < DEPTH: for each lane i with be[i]=1, that lane of mem[addr] ← that lane of data_in. Other lanes are unchanged. be = 0 is a legal no-op.
  - Read (mode=0), addr < DEPTH: data_out ← mem[addr] (pre-edge contents), rd_valid ← 1.
  - addr ≥ DEPTH: addr_err ← 1. A write changes no memory. A read sets data_out ← 0 and rd_valid ← 1.
- rd_valid and addr_err are 0 on every edge with no accepted access of the matching kind. data_out holds between reads.
- Only one access per cycle (single port). Back-to-back accesses every cycle are legal.

## Timing
- Read latency: 1 edge. With en=1, mode=0 at edge N, data_out and rd_valid are valid after edge N and until edge N+1.
- Write then read of the same address on consecutive edges returns the new data. A read issued the same cycle as a write is impossible (single port).
- Clear sweep takes exactly DEPTH edges with rst low. The first access that can be accepted is at edge DEPTH+1 after rst falls, or after the clr edge.
- rst asserted mid-sweep restarts the sweep from cnt=0 after release. Partially cleared words are overwritten by the restarted sweep.
- rst asserted mid-read clears data_out and rd_valid at that edge. Pending results are lost.
- DEPTH = 2^ADDR_W: addr_err can never assert.
- DEPTH = 1: sweep lasts 1 edge.

## Test plan
- Reset sweep (DATA_W=16, ADDR_W=6, DEPTH=48, CLR_VAL=16'hDEAD) -> busy high for 48 edges after rst falls, then low. Reading addresses 0..47 returns 16'hDEAD with rd_valid one edge later.
- Full write/read (defaults) -> write mem[i] = i+5 for i = 0..63 with be=1, then read 0..63. data_out == i+5 one edge after each read. rd_valid high only on those cycles.
- Lane mask (DATA_W=16) -> write 16'h1234 with be=2'b11, then 16'hABCD with be=2'b01 to addr 3. Reading addr 3 returns 16'h12CD.
- Out of range (ADDR_W=6, DEPTH=48) -> write to addr 50 sets addr_err=1 for one cycle. Reading addr 50 gives data_out=0, rd_valid=1, addr_err=1. Addr 2 (mod 48) is unchanged.
- clr versus access -> in IDLE assert clr together with a write to addr 5. The write is dropped, busy rises for DEPTH edges, and addr 5 reads CLR_VAL. Accesses during busy produce no rd_valid and no memory change.
- Reset mid-sweep -> rst pulse at sweep edge 10 gives busy continuously high and a sweep of a full DEPTH edges after release. data_out = 0 after the rst edge.
